// File: rtl/gates_sequencer_pkg.sv
// gates_sequencer_pkg: shared encodings and the reference truth table for the
// ten-LED gate-array exercise.
package gates_sequencer_pkg;

    // Operating modes, also the externally visible mode code.
    typedef enum logic [1:0] {
        ST_MANUAL = 2'b00,
        ST_AUTO   = 2'b01,
        ST_PAUSE  = 2'b10
    } mode_t;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_PAUSE  = 2'b10;

    // Known-good LED vector for each {a,b} pattern.
    localparam logic [9:0] EXP_LED_00 = 10'h3E4;
    localparam logic [9:0] EXP_LED_01 = 10'h0FE;
    localparam logic [9:0] EXP_LED_10 = 10'h0DA;
    localparam logic [9:0] EXP_LED_11 = 10'h003;

    // Look up the expected datapath result for a 2-bit pattern.
    function automatic logic [9:0] exp_led(input logic [1:0] pattern);
        logic [9:0] value;
        value = EXP_LED_00;
        case (pattern)
            2'b00:   value = EXP_LED_00;
            2'b01:   value = EXP_LED_01;
            2'b10:   value = EXP_LED_10;
            2'b11:   value = EXP_LED_11;
            default: value = EXP_LED_00;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/gates_sequencer_btn_sync.sv
// btn_sync_edge: multi-stage synchronizer for a raw board button plus a
// one-cycle rising-edge pulse. The pulse is qualified by a fill chain so a
// button already held when reset releases never produces a pulse: the edge
// detector only fires once both compared samples came from the real input.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   fill_q;

    // Synchronizer chain; bit 0 samples the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Previous synced level, used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Fill chain: top bit goes high once level and prev_q both hold real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = fill_q[SYNC_STAGES] & level & ~prev_q;

endmodule

// File: rtl/gates_sequencer.sv
// gates_sequencer: drives the a/b inputs of the gate-array datapath from the
// buttons (MANUAL) or from an auto-stepping 2-bit pattern (AUTO/PAUSE), and
// forwards the datapath result to the LEDs.
// Optional build macro GATES_SEQUENCER_CHECK_EN adds a truth-table comparator
// that flags the first failing pattern in AUTO; without it err/err_step are 0.
module gates_sequencer
    import gates_sequencer_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 50_000_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_mode,
    input  logic       btn_step,
    input  logic [9:0] gate_led,
    output logic       gate_a,
    output logic       gate_b,
    output logic [9:0] led,
    output logic [1:0] mode,
    output logic [1:0] step,
    output logic       err,
    output logic [1:0] err_step
);

    localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES - 1);

    logic a_level;
    logic b_level;
    logic mode_level_unused;
    logic step_level_unused;
    logic a_rise_unused;
    logic b_rise_unused;
    logic mode_pulse;
    logic step_pulse;

    mode_t       state_q;
    logic [1:0]  step_q;
    logic [31:0] div_q;
    logic        gate_a_q;
    logic        gate_b_q;
    logic [9:0]  led_q;
    logic        tick;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_a),
        .level (a_level),
        .rise  (a_rise_unused)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_b),
        .level (b_level),
        .rise  (b_rise_unused)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_mode),
        .level (mode_level_unused),
        .rise  (mode_pulse)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .level (step_level_unused),
        .rise  (step_pulse)
    );

    // Last cycle of a pattern period in AUTO.
    assign tick = (div_q == STEP_LAST);

    // Mode FSM with pattern counter, divider and registered datapath drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_MANUAL;
            step_q   <= 2'b00;
            div_q    <= '0;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
        end else begin
            case (state_q)
                ST_MANUAL: begin
                    gate_a_q <= a_level;
                    gate_b_q <= b_level;
                    div_q    <= '0;
                    if (mode_pulse) begin
                        state_q <= ST_AUTO;
                        step_q  <= 2'b00;
                    end
                end
                ST_AUTO: begin
                    gate_a_q <= step_q[1];
                    gate_b_q <= step_q[0];
                    if (tick) begin
                        div_q  <= '0;
                        step_q <= step_q + 2'd1;
                    end else begin
                        div_q <= div_q + 32'd1;
                    end
                    if (mode_pulse) begin
                        state_q <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    gate_a_q <= step_q[1];
                    gate_b_q <= step_q[0];
                    // Mode press takes priority over a coincident step press.
                    if (mode_pulse) begin
                        state_q <= ST_MANUAL;
                    end else if (step_pulse) begin
                        step_q <= step_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_MANUAL;
                end
            endcase
        end
    end

    // LED mirror of the datapath result, one cycle of latency in every mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= gate_led;
        end
    end

`ifdef GATES_SEQUENCER_CHECK_EN
    logic       err_q;
    logic [1:0] err_step_q;
    logic       mismatch;

    assign mismatch = (led_q != exp_led(step_q));

    // Sticky capture of the first pattern whose result disagrees with the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_step_q <= 2'b00;
        end else if (state_q == ST_MANUAL && mode_pulse) begin
            err_q      <= 1'b0;
            err_step_q <= 2'b00;
        end else if (state_q == ST_AUTO && tick && mismatch && !err_q) begin
            err_q      <= 1'b1;
            err_step_q <= step_q;
        end
    end

    assign err      = err_q;
    assign err_step = err_step_q;
`else
    assign err      = 1'b0;
    assign err_step = 2'b00;
`endif

    assign gate_a = gate_a_q;
    assign gate_b = gate_b_q;
    assign led    = led_q;
    assign mode   = state_q;
    assign step   = step_q;

endmodule

// File: tb/tb_gates_sequencer.sv
// tb_gates_sequencer: directed bench for gates_sequencer with STEP_CYCLES=4.
// A golden gate datapath closes the loop; a behavioural model predicts every
// output each cycle and hand-computed values pin key moments.
module tb_gates_sequencer;

    localparam int S = 2;
    localparam int N = 4;
`ifdef GATES_SEQUENCER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       btn_a;
    logic       btn_b;
    logic       btn_mode;
    logic       btn_step;
    logic [9:0] gate_led;
    logic       gate_a;
    logic       gate_b;
    logic [9:0] led;
    logic [1:0] mode;
    logic [1:0] step;
    logic       err;
    logic [1:0] err_step;
    logic       stuck3;

    int checks;
    int failures;

    gates_sequencer #(.STEP_CYCLES(N), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_a    (btn_a),
        .btn_b    (btn_b),
        .btn_mode (btn_mode),
        .btn_step (btn_step),
        .gate_led (gate_led),
        .gate_a   (gate_a),
        .gate_b   (gate_b),
        .led      (led),
        .mode     (mode),
        .step     (step),
        .err      (err),
        .err_step (err_step)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden gate datapath: NOR, NOR, NAND, NAND, NOT a, XOR, XOR, NOT a, OR, AND.
    function automatic logic [9:0] golden(input logic a, input logic b);
        return {~(a | b), ~a & ~b, ~(a & b), ~a | ~b, ~a, a ^ b,
                (a & ~b) | (~a & b), ~a, a | b, a & b};
    endfunction

    assign gate_led = golden(gate_a, gate_b) & (stuck3 ? 10'h3F7 : 10'h3FF);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [S:0] h_a, h_b, h_m, h_s;   // raw samples, bit 0 newest
    int         m_edges;
    int         m_mode, m_step, m_div, m_es;
    logic       m_err, m_ga, m_gb;
    logic [9:0] m_led;
    logic       m_mp, m_sp, m_tick;

    assign m_mp   = (m_edges > S) && h_m[S-1] && !h_m[S];
    assign m_sp   = (m_edges > S) && h_s[S-1] && !h_s[S];
    assign m_tick = (m_div == N - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_a <= '0; h_b <= '0; h_m <= '0; h_s <= '0;
            m_edges <= 0; m_mode <= 0; m_step <= 0; m_div <= 0;
            m_err <= 1'b0; m_es <= 0; m_ga <= 1'b0; m_gb <= 1'b0; m_led <= '0;
        end else begin
            h_a <= {h_a[S-1:0], btn_a};
            h_b <= {h_b[S-1:0], btn_b};
            h_m <= {h_m[S-1:0], btn_mode};
            h_s <= {h_s[S-1:0], btn_step};
            m_edges <= (m_edges > S) ? m_edges : m_edges + 1;
            m_led <= gate_led;
            if (m_mode == 0) begin
                m_ga <= h_a[S-1];
                m_gb <= h_b[S-1];
                m_div <= 0;
                if (m_mp) begin
                    m_mode <= 1; m_step <= 0; m_err <= 1'b0; m_es <= 0;
                end
            end else if (m_mode == 1) begin
                m_ga <= (m_step / 2) == 1;
                m_gb <= (m_step % 2) == 1;
                m_div <= m_tick ? 0 : m_div + 1;
                if (m_tick) begin
                    m_step <= (m_step + 1) % 4;
                    if (CHK && !m_err && m_led !== golden((m_step / 2) == 1, (m_step % 2) == 1)) begin
                        m_err <= 1'b1;
                        m_es  <= m_step;
                    end
                end
                if (m_mp) m_mode <= 2;
            end else begin
                m_ga <= (m_step / 2) == 1;
                m_gb <= (m_step % 2) == 1;
                if (m_mp) m_mode <= 0;
                else if (m_sp) m_step <= (m_step + 1) % 4;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("mdl_mode", 32'(mode), 32'(m_mode));
        check("mdl_step", 32'(step), 32'(m_step));
        check("mdl_gate_a", 32'(gate_a), 32'(m_ga));
        check("mdl_gate_b", 32'(gate_b), 32'(m_gb));
        check("mdl_led", 32'(led), 32'(m_led));
        check("mdl_err", 32'(err), 32'(m_err));
        check("mdl_err_step", 32'(err_step), 32'(m_es));
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cyc(4);
        btn_mode = 1'b0; cyc(4);
    endtask

    task automatic press_step();
        btn_step = 1'b1; cyc(4);
        btn_step = 1'b0; cyc(4);
    endtask

    task automatic wait_step(input int v, input string name);
        int k;
        k = 0;
        while (step !== 2'(v) && k < 100) begin
            cyc(1);
            k++;
        end
        check(name, 32'(step), 32'(v));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_mode"}, 32'(mode), 32'(0));
        check({name, "_step"}, 32'(step), 32'(0));
        check({name, "_gate_a"}, 32'(gate_a), 32'(0));
        check({name, "_gate_b"}, 32'(gate_b), 32'(0));
        check({name, "_led"}, 32'(led), 32'(0));
        check({name, "_err"}, 32'(err), 32'(0));
        check({name, "_err_step"}, 32'(err_step), 32'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int sp;
        int cnt;
        checks = 0; failures = 0;
        rst_n = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
        btn_mode = 1'b1; btn_step = 1'b0; stuck3 = 1'b0;
        cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc(6);
        check("held_mode_no_pulse", 32'(mode), 32'(0));
        btn_mode = 1'b0;
        cyc(4);

        // MANUAL: a=1, b=0 appears on gate_a after SYNC_STAGES+1 cycles.
        btn_a = 1'b1;
        cyc(2);
        check("manual_gate_a_early", 32'(gate_a), 32'(0));
        cyc(1);
        check("manual_gate_a", 32'(gate_a), 32'(1));
        check("manual_gate_b", 32'(gate_b), 32'(0));
        cyc(1);
        check("manual_led", 32'(led), 32'h0DA);
        btn_a = 1'b0;

        // AUTO: each pattern lasts exactly N cycles.
        press_mode();
        check("auto_mode", 32'(mode), 32'(1));
        wait_step(0, "wait_s0");
        wait_step(1, "wait_s1");
        for (int i = 0; i < 16; i++) begin
            check("auto_seq", 32'(step), 32'((1 + i / 4) % 4));
            cyc(1);
        end
        cyc(48);
        check("auto_no_err", 32'(err), 32'(0));

        // Stuck-at-0 on led bit 3: patterns 01 and 10 disagree.
        wait_step(0, "wait_stuck_s0");
        stuck3 = 1'b1;
        wait_step(2, "wait_stuck_s2");
        cyc(1);
        check("stuck_err", 32'(err), 32'(CHK));
        check("stuck_err_step", 32'(err_step), CHK ? 32'(1) : 32'(0));
        wait_step(3, "wait_stuck_s3");
        cyc(1);
        check("stuck_err_step_kept", 32'(err_step), CHK ? 32'(1) : 32'(0));
        stuck3 = 1'b0;

        // PAUSE: frozen, then single steps.
        press_mode();
        check("pause_mode", 32'(mode), 32'(2));
        sp = int'(step);
        cyc(20);
        check("pause_frozen", 32'(step), 32'(sp));
        press_step();
        press_step();
        check("pause_two_steps", 32'(step), 32'((sp + 2) % 4));

        // Coincident mode and step presses: mode wins.
        btn_mode = 1'b1; btn_step = 1'b1; cyc(4);
        btn_mode = 1'b0; btn_step = 1'b0; cyc(4);
        check("simul_mode", 32'(mode), 32'(0));
        check("simul_step", 32'(step), 32'((sp + 2) % 4));

        // Re-enter AUTO clears err; reset mid-period.
        press_mode();
        check("reenter_mode", 32'(mode), 32'(1));
        check("reenter_err_clear", 32'(err), 32'(0));
        wait_step(0, "wait_r_s0");
        wait_step(1, "wait_r_s1");
        cyc(2);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        cyc(2);
        rst_n = 1'b1;
        cyc(4);

        // First tick after AUTO entry comes after exactly N cycles.
        btn_mode = 1'b1;
        cnt = 0;
        while (mode !== 2'b01 && cnt < 20) begin
            cyc(1);
            cnt++;
        end
        check("post_reset_auto", 32'(mode), 32'(1));
        cnt = 0;
        while (step === 2'b00 && cnt < 20) begin
            cnt++;
            cyc(1);
        end
        check("first_tick_len", 32'(cnt), 32'(N));
        check("post_reset_err", 32'(err), 32'(0));
        btn_mode = 1'b0;
        cyc(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
